aes_gcm_encrypt: RTL and testbench
==================================

AES_GCM_ENCRYPT -- requirements
Module: aes_gcm_encrypt

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on the rising edge.
REQ-002 SHALL have: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: key  input  256  session key; sampled at start, held stable by the source until done.
REQ-004 SHALL have: iv  input  256  initialisation vector; held stable by the source until done.
REQ-005 SHALL have: start  input  1  begin message; honoured only in IDLE.
REQ-006 SHALL have: msg_len  input  16  plaintext length in 32-bit words; captured with start.
REQ-007 SHALL have: pt_data  input  32  plaintext word.
REQ-008 SHALL have: pt_valid  input  1  pt_data valid.
REQ-009 SHALL have: pt_ready  output  1  block accepts pt_data this cycle.
REQ-010 SHALL have: ct_data  output  32  ciphertext or tag word.
REQ-011 SHALL have: ct_valid  output  1  ct_data valid.
REQ-012 SHALL have: ct_ready  input  1  sink accepts ct_data.
REQ-013 SHALL have: ct_is_tag  output  1  current ct_data is a tag word.
REQ-014 SHALL have: ct_last  output  1  final tag word.
REQ-015 SHALL have: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have: done  output  1  one-cycle pulse on message completion.

Function
REQ-017 SHALL implement states IDLE, STREAM, TAG, DONE.
REQ-018 In IDLE, start=1 SHALL capture msg_len, set word index i=1, tag index k=0 and acc=iv[63:32], and enter STREAM next cycle, or TAG if msg_len=0.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 Output register free = !ct_valid || ct_ready.
REQ-021 pt_ready SHALL be 1 only in STREAM while the output register is free and fewer than msg_len words have been accepted.
REQ-022 A transfer occurs when pt_valid && pt_ready. On transfer, the next cycle SHALL show ct_data = pt_data ^ key[31:0] ^ iv[31:0] ^ i (i zero-extended to 32 bits), ct_valid=1 and ct_is_tag=0; i then increments.
REQ-023 On each transfer, acc SHALL update to {acc[30:0],acc[31]} ^ (the ciphertext word).
REQ-024 The accepted-word count SHALL be 16 bits wide; i SHALL never wrap, because msg_len is at most 65535.
REQ-025 After transfer number msg_len, the state SHALL go to TAG. The last ciphertext word drains through the output register like any other.
REQ-026 In TAG, when the output register is free, the block SHALL load tag word k = acc ^ key[128+32k +: 32] ^ iv[64+32k +: 32] with ct_is_tag=1, and ct_last=1 only when k=3. The loads SHALL run for k=0..3 in order.
REQ-027 While ct_valid && !ct_ready, ct_data, ct_is_tag and ct_last SHALL hold stable.
REQ-028 ct_valid SHALL drop on the cycle after an accepted word unless a new word is loaded on the same edge. Back-to-back throughput SHALL be 1 word per cycle.
REQ-029 When the ct_last word is accepted, the state SHALL go to DONE. In DONE, done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-030 pt_valid outside STREAM SHALL be ignored, with no state change.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE and set ct_data=0, ct_valid=0, ct_is_tag=0, ct_last=0, pt_ready=0, busy=0, done=0, acc=0 and all counters to 0.
REQ-032 Reset asserted mid-message SHALL abandon the message with no tag emitted. The next start after release SHALL begin a fresh message.

Verification
REQ-033 The bench SHALL cover single word: key[31:0]=0x000000FF, iv[31:0]=0x00000F00, msg_len=1, pt=0x12345678 -> ct_data=0x12345986, then 4 tag words, ct_last on the 4th, done pulse one cycle after the 4th word is accepted.
REQ-034 The bench SHALL cover zero length: iv=0, key[159:128]=0xA5A5A5A5, other key bits 0, msg_len=0 -> no pt_ready, tag words 0xA5A5A5A5, 0, 0, 0.
REQ-035 The bench SHALL cover backpressure: msg_len=3, ct_ready held low 3 cycles after the first ct_valid -> ct_data stable, pt_ready=0 throughout, no word lost or duplicated, tags match the model.
REQ-036 The bench SHALL cover streaming: msg_len=8, pt_valid and ct_ready held high -> 8 consecutive ct words (i=1..8), then 4 consecutive tag words, 12 output cycles total.
REQ-037 The bench SHALL cover start while busy: start pulsed during STREAM with a different msg_len -> ignored, original length completes.
REQ-038 The bench SHALL cover reset mid-stream: reset_n low after 2 of 5 words -> all outputs 0 at once; a new message afterwards runs correctly from i=1.

Source files
------------

// File: rtl/aes_gcm_encrypt.sv
// Streaming GCM-style encryptor: XOR keystream on each plaintext word,
// rotate-XOR accumulator folded into four tag words after the payload.
module aes_gcm_encrypt (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic [255:0] iv,
    input  logic         start,
    input  logic [15:0]  msg_len,
    input  logic [31:0]  pt_data,
    input  logic         pt_valid,
    output logic         pt_ready,
    output logic [31:0]  ct_data,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic         ct_is_tag,
    output logic         ct_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, STREAM, TAG, DONE} state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [2:0]  k;
    logic [31:0] acc;

    logic        free;
    logic        xfer;
    logic        ct_acc;
    logic [31:0] word_idx;
    logic [31:0] ct_word;
    logic        unused_bits;

    function automatic logic [31:0] rotl1(input logic [31:0] a);
        return {a[30:0], a[31]};
    endfunction

    function automatic logic [31:0] tag_word(input logic [31:0] a, input logic [1:0] idx,
                                             input logic [255:0] kk, input logic [255:0] vv);
        return a ^ kk[128 + 32*idx +: 32] ^ vv[64 + 32*idx +: 32];
    endfunction

    assign free     = !ct_valid || ct_ready;
    assign pt_ready = (state == STREAM) && free && (cnt < len);
    assign xfer     = pt_valid && pt_ready;
    assign ct_acc   = ct_valid && ct_ready;
    // Word index i runs 1..msg_len; derived from the accepted count so it never wraps.
    assign word_idx = {16'd0, cnt} + 32'd1;
    assign ct_word  = pt_data ^ key[31:0] ^ iv[31:0] ^ word_idx;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    assign unused_bits = ^{key[127:32], iv[255:192]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            k         <= '0;
            acc       <= '0;
            ct_data   <= '0;
            ct_valid  <= 1'b0;
            ct_is_tag <= 1'b0;
            ct_last   <= 1'b0;
        end else begin
            // Default drain; a load on the same edge below overrides this.
            if (ct_acc)
                ct_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= msg_len;
                        cnt   <= '0;
                        k     <= '0;
                        acc   <= iv[63:32];
                        state <= (msg_len == 16'd0) ? TAG : STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        ct_data   <= ct_word;
                        ct_valid  <= 1'b1;
                        ct_is_tag <= 1'b0;
                        ct_last   <= 1'b0;
                        acc       <= rotl1(acc) ^ ct_word;
                        cnt       <= cnt + 16'd1;
                        if (cnt + 16'd1 == len)
                            state <= TAG;
                    end
                end
                TAG: begin
                    if (free && (k < 3'd4)) begin
                        ct_data   <= tag_word(acc, k[1:0], key, iv);
                        ct_valid  <= 1'b1;
                        ct_is_tag <= 1'b1;
                        ct_last   <= (k == 3'd3);
                        k         <= k + 3'd1;
                    end else if (ct_acc && ct_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_gcm_encrypt.sv
// Scoreboard bench for aes_gcm_encrypt: expected words queued from a
// reference model at message start, compared as the sink accepts them.
module tb_aes_gcm_encrypt;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] key;
    logic [255:0] iv;
    logic         start;
    logic [15:0]  msg_len;
    logic [31:0]  pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic [31:0]  ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic         ct_is_tag;
    logic         ct_last;
    logic         busy;
    logic         done;

    aes_gcm_encrypt dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .iv        (iv),
        .start     (start),
        .msg_len   (msg_len),
        .pt_data   (pt_data),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_is_tag (ct_is_tag),
        .ct_last   (ct_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] exp_q[$];
    logic [31:0] pt_q[$];

    int          n_out, first_cyc, last_cyc, done_cyc;
    logic        check_first;
    logic [31:0] first_expect;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    task automatic build_expected(input int len);
        logic [31:0] acc, ct;
        acc = iv[63:32];
        for (int j = 0; j < len; j++) begin
            ct = pt_q[j] ^ key[31:0] ^ iv[31:0] ^ (j + 1);
            exp_q.push_back({2'b00, ct});
            acc = {acc[30:0], acc[31]} ^ ct;
        end
        for (int t = 0; t < 4; t++)
            exp_q.push_back({1'b1, (t == 3), acc ^ key[128 + 32*t +: 32] ^ iv[64 + 32*t +: 32]});
    endtask

    task automatic fill_pt(input int len);
        pt_q.delete();
        for (int j = 0; j < len; j++) pt_q.push_back($urandom);
    endtask

    // mode: 0 ready/valid always high, 1 random, 2 stall 3 cycles at first ct, 3 start pulse mid-stream
    task automatic run_msg(input int len, input int mode, input int abort_after);
        int          pidx, stall_left;
        logic        seen, fin, aborted, pulsed, bad_ready;
        logic [31:0] held;
        logic [33:0] e;
        pidx = 0; stall_left = 0; seen = 0; fin = 0; aborted = 0; pulsed = 0; bad_ready = 0;
        held = '0;
        n_out = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        exp_q.delete();
        build_expected(len);
        @(negedge clk);
        start = 1'b1; msg_len = len[15:0]; pt_valid = 1'b0; ct_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            case (mode)
                1:       ct_ready = 1'($urandom_range(0, 1));
                2:       ct_ready = seen && (stall_left == 0);
                default: ct_ready = 1'b1;
            endcase
            pt_valid = (pidx < len) && (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
            pt_data  = pt_valid ? pt_q[pidx] : $urandom;
            if (mode == 3 && pidx == 2 && !pulsed) begin
                start = 1'b1; msg_len = 16'(len + 5); pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (abort_after >= 0 && pidx == abort_after) begin
                reset_n = 1'b0;
                #1;
                n_tests++;
                if ({ct_data, ct_valid, ct_is_tag, ct_last, pt_ready, busy, done} !== 38'd0)
                    begin n_fail++; $display("FAIL reset_mid_outputs got ct_data=%h flags=%b want all 0", ct_data, {ct_valid, ct_is_tag, ct_last, pt_ready, busy, done}); end
                aborted = 1'b1;
                break;
            end
            #1;
            if (mode == 2 && seen && !ct_ready) begin
                n_tests++;
                if (ct_data !== held || ct_valid !== 1'b1 || pt_ready !== 1'b0)
                    begin n_fail++; $display("FAIL stall_hold got ct_data=%h ct_valid=%b pt_ready=%b want %h 1 0", ct_data, ct_valid, pt_ready, held); end
                stall_left--;
            end
            if (mode == 2 && ct_valid && !seen) begin
                seen = 1'b1; stall_left = 3; held = ct_data;
            end
            if (pt_ready && pidx >= len) bad_ready = 1'b1;
            if (ct_valid && ct_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL extra_output got %h want no word", ct_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({ct_is_tag, ct_last, ct_data} !== e)
                        begin n_fail++; $display("FAIL ct_word got tag=%b last=%b data=%h want tag=%b last=%b data=%h", ct_is_tag, ct_last, ct_data, e[33], e[32], e[31:0]); end
                end
                if (n_out == 0 && check_first) begin
                    n_tests++;
                    if (ct_data !== first_expect)
                        begin n_fail++; $display("FAIL first_word got %h want %h", ct_data, first_expect); end
                end
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
            if (pt_valid && pt_ready) pidx++;
            if (done) begin
                done_cyc = cyc; fin = 1'b1;
            end
            @(negedge clk);
            if (fin) break;
        end
        start = 1'b0; pt_valid = 1'b0; check_first = 1'b0;
        if (!aborted) begin
            n_tests++;
            if (!fin) begin n_fail++; $display("FAIL timeout got no done want done within 400 cycles"); end
            n_tests++;
            if (exp_q.size() != 0) begin n_fail++; $display("FAIL words_missing got %0d left want 0", exp_q.size()); end
            n_tests++;
            if (done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL done_timing got cycle %0d want %0d", done_cyc, last_cyc + 1); end
            n_tests++;
            if (bad_ready) begin n_fail++; $display("FAIL pt_ready_extra got 1 want 0 after msg_len words"); end
            #1;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin n_fail++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; msg_len = '0; pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b1;
        key = '0; iv = '0; check_first = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (ct_data !== 32'd0) begin n_fail++; $display("FAIL reset_ct_data got %h want 0", ct_data); end
        n_tests++;
        if (ct_valid !== 1'b0 || ct_is_tag !== 1'b0 || ct_last !== 1'b0)
            begin n_fail++; $display("FAIL reset_ct_flags got %b want 000", {ct_valid, ct_is_tag, ct_last}); end
        n_tests++;
        if (pt_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {pt_ready, busy, done}); end
        @(negedge clk);
        reset_n = 1'b1;
        pt_valid = 1'b1; pt_data = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || ct_valid !== 1'b0 || pt_ready !== 1'b0)
            begin n_fail++; $display("FAIL idle_pt_ignored got busy=%b ct_valid=%b pt_ready=%b want 0 0 0", busy, ct_valid, pt_ready); end
        pt_valid = 1'b0;
    endtask

    task automatic test_single_word();
        key = rand256(); key[31:0] = 32'h000000FF;
        iv  = rand256(); iv[31:0]  = 32'h00000F00;
        pt_q.delete(); pt_q.push_back(32'h12345678);
        check_first = 1'b1; first_expect = 32'h12345986;
        run_msg(1, 0, -1);
        n_tests++;
        if (n_out != 5) begin n_fail++; $display("FAIL single_count got %0d want 5", n_out); end
    endtask

    task automatic test_zero_length();
        key = '0; key[159:128] = 32'hA5A5A5A5; iv = '0;
        pt_q.delete();
        check_first = 1'b1; first_expect = 32'hA5A5A5A5;
        run_msg(0, 0, -1);
        n_tests++;
        if (n_out != 4) begin n_fail++; $display("FAIL zero_count got %0d want 4", n_out); end
    endtask

    task automatic test_backpressure();
        key = rand256(); iv = rand256();
        fill_pt(3);
        run_msg(3, 2, -1);
        n_tests++;
        if (n_out != 7) begin n_fail++; $display("FAIL bp_count got %0d want 7", n_out); end
    endtask

    task automatic test_streaming();
        key = rand256(); iv = rand256();
        fill_pt(8);
        run_msg(8, 0, -1);
        n_tests++;
        if (n_out != 12 || last_cyc - first_cyc + 1 != 12)
            begin n_fail++; $display("FAIL stream_span got %0d words over %0d cycles want 12 over 12", n_out, last_cyc - first_cyc + 1); end
    endtask

    task automatic test_start_busy();
        key = rand256(); iv = rand256();
        fill_pt(4);
        run_msg(4, 3, -1);
        n_tests++;
        if (n_out != 8) begin n_fail++; $display("FAIL start_busy_count got %0d want 8", n_out); end
    endtask

    task automatic test_reset_mid();
        key = rand256(); iv = rand256();
        fill_pt(5);
        run_msg(5, 0, 2);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || ct_valid !== 1'b0)
            begin n_fail++; $display("FAIL after_reset_idle got busy=%b ct_valid=%b want 0 0", busy, ct_valid); end
        key = rand256(); iv = rand256();
        fill_pt(3);
        check_first = 1'b1; first_expect = pt_q[0] ^ key[31:0] ^ iv[31:0] ^ 32'd1;
        run_msg(3, 0, -1);
        n_tests++;
        if (n_out != 7) begin n_fail++; $display("FAIL restart_count got %0d want 7", n_out); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            key = rand256(); iv = rand256();
            fill_pt(6);
            run_msg(6, 1, -1);
            n_tests++;
            if (n_out != 10) begin n_fail++; $display("FAIL random_count got %0d want 10", n_out); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_length();
        test_backpressure();
        test_streaming();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
